// File: rtl/conv_layer_sequencer.sv
// Layer-pass controller for conv_final -> max_pooling: loads the kernel serially,
// streams the image buffer as conv input, then waits for the pooled outputs or a timeout.
module conv_layer_sequencer #(
  parameter int N        = 6,
  parameter int M        = 6,
  parameter int K        = 3,
  parameter int P        = 2,
  parameter int P_stride = 2,
  parameter int K_stride = 1,
  parameter int TIMEOUT  = 1023,
  localparam int AW      = $clog2(N*M)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       kernel_in,
  input  logic              kernel_valid,
  output logic              img_rd_en,
  output logic [AW-1:0]     img_addr,
  input  logic [15:0]       img_data,
  output logic [15:0]       pxl_out,
  output logic              pxl_valid,
  output logic [16*K*K-1:0] kernel_data,
  input  logic              pool_valid,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [9:0]        pool_count
);

  localparam int NPIX     = N*M;
  localparam int KK       = K*K;
  localparam int KW       = 16*KK;
  localparam int KIW      = $clog2(KK+1);
  localparam int TW       = $clog2(TIMEOUT+1);
  localparam int EXP_POOL = (((M-K)/K_stride+1-P)/P_stride+1) *
                            (((N-K)/K_stride+1-P)/P_stride+1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_K, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [KIW-1:0] kidx_q, kidx_d;
  logic [KW-1:0]  kern_q, kern_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [9:0]     pc_q, pc_d;
  logic           err_q, err_d;
  logic           pxv_q, pxv_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      kidx_q  <= '0;
      kern_q  <= '0;
      addr_q  <= '0;
      tcnt_q  <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
      pxv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kidx_q  <= kidx_d;
      kern_q  <= kern_d;
      addr_q  <= addr_d;
      tcnt_q  <= tcnt_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      pxv_q   <= pxv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kidx_d  = kidx_q;
    kern_d  = kern_q;
    addr_d  = '0;
    tcnt_d  = '0;
    pc_d    = pc_q;
    err_d   = err_q;
    pxv_d   = (state_q == S_STREAM) && !abort;

    // Count is updated before the DRAIN exit decision so a final pulse beats the timeout.
    if ((state_q == S_STREAM || state_q == S_DRAIN) && pool_valid && pc_q != 10'(EXP_POOL))
      pc_d = pc_q + 10'd1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_K;
          pc_d    = '0;
          err_d   = 1'b0;
          kidx_d  = '0;
        end
      end
      S_LOAD_K: begin
        if (kernel_valid) begin
          kern_d = {kern_q[KW-17:0], kernel_in};
          kidx_d = kidx_q + 1'b1;
          if (kidx_q == KIW'(KK-1)) state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == AW'(NPIX-1)) begin
          addr_d  = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        tcnt_d = tcnt_q + 1'b1;
        if (pc_d == 10'(EXP_POOL)) begin
          state_d = S_DONE;
        end else if (tcnt_d == TW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      pc_d    = pc_q;
      err_d   = err_q;
      addr_d  = '0;
      tcnt_d  = '0;
    end
  end

  // The buffer returns data one cycle after the read, aligned with the registered valid.
  assign pxl_out     = pxv_q ? img_data : '0;
  assign pxl_valid   = pxv_q;
  assign img_rd_en   = (state_q == S_STREAM);
  assign img_addr    = addr_q;
  assign kernel_data = kern_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign error       = err_q;
  assign pool_count  = pc_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Randomized scoreboard bench for conv_layer_sequencer with a behavioural image buffer.
module tb_conv_layer_sequencer;

  localparam int NPIX = 36;
  localparam int KW   = 144;
  localparam int EXPP = 4;
  localparam int TO   = 20;

  typedef logic [159:0] w_t;
  typedef struct {
    logic          err;
    logic [9:0]    pc;
    logic [KW-1:0] kern;
  } done_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   kernel_in = '0;
  logic          kernel_valid = 1'b0;
  logic          img_rd_en;
  logic [5:0]    img_addr;
  logic [15:0]   img_data = '0;
  logic [15:0]   pxl_out;
  logic          pxl_valid;
  logic [KW-1:0] kernel_data;
  logic          pool_valid = 1'b0;
  logic          busy;
  logic          done;
  logic          error;
  logic [9:0]    pool_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:NPIX-1];
  logic [15:0] px_q [$];
  int          run_q [$];
  done_t       done_q [$];

  conv_layer_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .kernel_in(kernel_in), .kernel_valid(kernel_valid),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .img_data(img_data),
    .pxl_out(pxl_out), .pxl_valid(pxl_valid), .kernel_data(kernel_data),
    .pool_valid(pool_valid), .busy(busy), .done(done), .error(error),
    .pool_count(pool_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (img_rd_en) img_data <= mem[img_addr];

  task automatic chk(input string nm, input w_t act, input w_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pixel stream monitor: order/data and contiguous run length.
  int          run = 0;
  logic [15:0] px_e;
  always @(negedge clk) begin
    if (pxl_valid) begin
      run++;
      if (px_q.size() == 0) chk("pxl_unexpected", w_t'(pxl_valid), w_t'(0));
      else begin
        px_e = px_q.pop_front();
        chk("pxl_out", w_t'(pxl_out), w_t'(px_e));
      end
    end else if (run > 0) begin
      if (run_q.size() == 0) chk("run_unexpected", w_t'(run), w_t'(0));
      else chk("pxl_run_len", w_t'(run), w_t'(run_q.pop_front()));
      run = 0;
    end
  end

  // Completion monitor.
  done_t dr;
  always @(negedge clk) begin
    if (done) begin
      if (done_q.size() == 0) chk("done_unexpected", w_t'(done), w_t'(0));
      else begin
        dr = done_q.pop_front();
        chk("done_error", w_t'(error), w_t'(dr.err));
        chk("done_pool_count", w_t'(pool_count), w_t'(dr.pc));
        chk("done_kernel", w_t'(kernel_data), w_t'(dr.kern));
      end
    end
  end

  function automatic bit pulse(input int c, input int n);
    return (c >= 4) && ((c - 4) % 5 == 0) && ((c - 4) / 5 < n);
  endfunction

  task automatic chk_all_zero(input string nm);
    chk(nm, w_t'({img_rd_en, img_addr, pxl_out, pxl_valid, busy, done, error, pool_count}), w_t'(0));
    chk({nm, "_kernel"}, w_t'(kernel_data), w_t'(0));
  endtask

  // kmode: 0 = all-ones kernel, image 1..36, no gaps; 1 = kernel 1..9 with gaps; 2 = random
  task automatic run_pass(input int npool, input int kmode, input bit stray,
                          input int abort_at, input bit rst_drain);
    logic [KW-1:0] kexp;
    logic [15:0]   w;
    logic [9:0]    exp_pc;
    int            gaps, n, exp_n, apc;
    kexp   = '0;
    exp_pc = 10'((npool < EXPP) ? npool : EXPP);
    for (int i = 0; i < NPIX; i++) begin
      mem[i] = (kmode == 0) ? 16'(i + 1) : 16'($urandom);
      px_q.push_back(mem[i]);
    end
    @(posedge clk); #1;
    start = 1'b1; kernel_valid = 1'b1; kernel_in = 16'hDEAD;
    @(posedge clk); #1;
    start = 1'b0; kernel_valid = 1'b0;
    chk("start_busy", w_t'(busy), w_t'(1));
    chk("start_err_clr", w_t'(error), w_t'(0));
    chk("start_pc_clr", w_t'(pool_count), w_t'(0));
    for (int k = 0; k < 9; k++) begin
      w    = (kmode == 0) ? 16'd1 : (kmode == 1) ? 16'(k + 1) : 16'($urandom);
      gaps = (kmode == 0) ? 0 : $urandom_range(0, 2);
      repeat (gaps) begin
        kernel_valid = 1'b0; kernel_in = 16'($urandom);
        @(posedge clk); #1;
        chk("load_wait_rd_en", w_t'(img_rd_en), w_t'(0));
      end
      kernel_valid = 1'b1; kernel_in = w;
      kexp = {kexp[KW-17:0], w};
      @(posedge clk); #1;
      chk("load_rd_en", w_t'(img_rd_en), w_t'(k == 8));
    end
    kernel_valid = 1'b0;
    if (abort_at < 0 && !rst_drain) done_q.push_back('{npool < EXPP, exp_pc, kexp});
    run_q.push_back(abort_at < 0 ? NPIX : abort_at);
    for (int c = 0; c < NPIX; c++) begin
      chk("stream_addr", w_t'(img_addr), w_t'(c));
      pool_valid   = pulse(c, npool);
      start        = stray && (c == 15);
      kernel_valid = (c == 20);
      kernel_in    = 16'($urandom);
      abort        = (c == abort_at);
      @(posedge clk); #1;
      pool_valid = 1'b0; start = 1'b0; kernel_valid = 1'b0;
      if (abort) begin
        abort = 1'b0;
        apc = 0;
        for (int j = 0; j < abort_at; j++) if (pulse(j, npool)) apc++;
        chk("abort_rd_en", w_t'(img_rd_en), w_t'(0));
        chk("abort_pxl_valid", w_t'(pxl_valid), w_t'(0));
        chk("abort_busy", w_t'(busy), w_t'(0));
        chk("abort_done", w_t'(done), w_t'(0));
        chk("abort_pc_hold", w_t'(pool_count), w_t'(apc));
        px_q.delete();
        repeat (3) @(posedge clk);
        #1;
        return;
      end
    end
    chk("drain_rd_en", w_t'(img_rd_en), w_t'(0));
    if (rst_drain) begin
      @(posedge clk); @(posedge clk);
      #3 reset = 1'b0;
      #1 chk_all_zero("reset_mid_drain");
      start = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
        chk("reset_start_ignored", w_t'(busy), w_t'(0));
      end
      start = 1'b0;
      #2 reset = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_idle", w_t'(busy), w_t'(0));
      return;
    end
    exp_n = (npool >= EXPP) ? 1 : TO;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_latency", w_t'(n), w_t'(exp_n));
    chk("done_busy", w_t'(busy), w_t'(1));
    @(posedge clk); #1;
    chk("idle_busy", w_t'(busy), w_t'(0));
    chk("idle_done", w_t'(done), w_t'(0));
    chk("idle_pc_hold", w_t'(pool_count), w_t'(exp_pc));
    chk("idle_err_hold", w_t'(error), w_t'(npool < EXPP));
    chk("idle_kernel_hold", w_t'(kernel_data), w_t'(kexp));
  endtask

  initial begin
    #1 reset = 1'b0;
    #22 chk_all_zero("reset_state");
    reset = 1'b1;
    run_pass(4, 0, 1'b0, -1, 1'b0);
    run_pass(4, 1, 1'b0, -1, 1'b0);
    run_pass(3, 2, 1'b0, -1, 1'b0);
    run_pass(5, 2, 1'b1, -1, 1'b0);
    run_pass(6, 2, 1'b0, 10, 1'b0);
    run_pass(4, 2, 1'b0, -1, 1'b0);
    run_pass(6, 2, 1'b1, -1, 1'b0);
    run_pass(0, 2, 1'b0, -1, 1'b1);
    run_pass(4, 0, 1'b0, -1, 1'b0);
    for (int r = 0; r < 3; r++)
      run_pass($urandom_range(0, 6), 2, 1'($urandom_range(0, 1)), -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("px_q_drained", w_t'(px_q.size()), w_t'(0));
    chk("run_q_drained", w_t'(run_q.size()), w_t'(0));
    chk("done_q_drained", w_t'(done_q.size()), w_t'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
